// File: rtl/stream_pkg.sv
// Shared definitions for the stream width converters (packer/unpacker).
package stream_pkg;

    localparam int MAX_PACK_RATIO = 64;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Registered output holding stage: load has priority, pop drains the word.
module stream_out_reg
    import stream_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         full_n_i,
    input  logic         write_ce_i,
    output logic         valid_o,
    output logic         pop_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign pop_o   = valid_q & full_n_i & write_ce_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // A load in the same cycle as a pop replaces the word without a bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (pop_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/stream_packer.sv
// Narrow-to-wide stream packer; STREAM_PACKER_EOT_EN adds in_eot/out_keep
// for short end-of-transfer packets.
module stream_packer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    parameter int RATIO    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_empty_n,
    input  logic                      in_read_ce,
    output logic                      in_read,
    input  logic [IN_WIDTH-1:0]       in_dout,
`ifdef STREAM_PACKER_EOT_EN
    input  logic                      in_eot,
    output logic [RATIO-1:0]          out_keep,
`endif
    input  logic                      out_full_n,
    input  logic                      out_write_ce,
    output logic                      out_write,
    output logic [IN_WIDTH*RATIO-1:0] out_din
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CNT_WIDTH = clog2_min1(RATIO);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(RATIO - 1);
`ifdef STREAM_PACKER_EOT_EN
    localparam int REG_W = OUT_WIDTH + RATIO;
`else
    localparam int REG_W = OUT_WIDTH;
`endif

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] lanes_q, lanes_d;
    logic [OUT_WIDTH-1:0] packed_w;
    logic [REG_W-1:0]     reg_d, reg_q;
    logic                 last, stall, accept, emit;
    logic                 out_valid, out_pop;

`ifdef STREAM_PACKER_EOT_EN
    assign last = (cnt_q == LAST_CNT) | in_eot;
`else
    assign last = (cnt_q == LAST_CNT);
`endif

    assign stall   = last & out_valid & ~out_pop;
    assign in_read = in_empty_n & in_read_ce & ~stall & ~reset;
    assign accept  = in_read;
    assign emit    = accept & last;

    // Lanes above cnt stay zero because the buffer is cleared on every emit.
    always_comb begin
        packed_w = lanes_q;
        lanes_d  = lanes_q;
        cnt_d    = cnt_q;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt_q == CNT_WIDTH'(k))
                packed_w[k*IN_WIDTH +: IN_WIDTH] = in_dout;
        end
        if (emit) begin
            lanes_d = '0;
            cnt_d   = '0;
        end else if (accept) begin
            lanes_d = packed_w;
            cnt_d   = cnt_q + 1'b1;
        end
    end

`ifdef STREAM_PACKER_EOT_EN
    logic [RATIO-1:0] keep_w;

    always_comb begin
        keep_w = '0;
        for (int k = 0; k < RATIO; k++)
            keep_w[k] = (CNT_WIDTH'(k) <= cnt_q);
    end

    assign reg_d    = {keep_w, packed_w};
    assign out_keep = reg_q[REG_W-1:OUT_WIDTH];
`else
    assign reg_d = packed_w;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            lanes_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
        end
    end

    stream_out_reg #(
        .W(REG_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load_i    (emit),
        .data_i    (reg_d),
        .full_n_i  (out_full_n),
        .write_ce_i(out_write_ce),
        .valid_o   (out_valid),
        .pop_o     (out_pop),
        .data_o    (reg_q)
    );

    assign out_write = out_valid;
    assign out_din   = reg_q[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_stream_packer.sv
// Randomized and directed bench for stream_packer (IN_WIDTH=8, RATIO=4).
module tb_stream_packer;

    localparam int IW = 8;
    localparam int R  = 4;
    localparam int OW = IW * R;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_empty_n;
    logic          in_read_ce;
    logic          in_read;
    logic [IW-1:0] in_dout;
    logic          out_full_n;
    logic          out_write_ce;
    logic          out_write;
    logic [OW-1:0] out_din;
`ifdef STREAM_PACKER_EOT_EN
    logic          in_eot;
    logic [R-1:0]  out_keep;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: accepted narrow words awaiting a packet, and
    // completed wide words not yet taken by the sink.
    logic [IW-1:0] acc[$];
    logic [OW-1:0] exp_q[$];
    logic [R-1:0]  keep_q[$];

    logic          o_read, o_write;
    logic [OW-1:0] o_din;
    logic [R-1:0]  o_keep;
    logic          e_read, e_write, e_pop;
    logic [OW-1:0] e_din;
    logic [R-1:0]  e_keep;

    stream_packer #(
        .IN_WIDTH(IW),
        .RATIO   (R)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_empty_n  (in_empty_n),
        .in_read_ce  (in_read_ce),
        .in_read     (in_read),
        .in_dout     (in_dout),
`ifdef STREAM_PACKER_EOT_EN
        .in_eot      (in_eot),
        .out_keep    (out_keep),
`endif
        .out_full_n  (out_full_n),
        .out_write_ce(out_write_ce),
        .out_write   (out_write),
        .out_din     (out_din)
    );

    always #5 clk = ~clk;

    // Apply current inputs for one cycle: sample DUT and model at negedge,
    // advance the model to what the next posedge commits.
    task automatic step();
        logic          eot_m;
        logic [OW-1:0] w;
        logic [R-1:0]  k;
        @(negedge clk);
        o_read  = in_read;
        o_write = out_write;
        o_din   = out_din;
        eot_m   = 1'b0;
        o_keep  = '0;
`ifdef STREAM_PACKER_EOT_EN
        o_keep  = out_keep;
        eot_m   = in_eot;
`endif
        e_write = (exp_q.size() != 0);
        e_din   = e_write ? exp_q[0] : '0;
        e_keep  = e_write ? keep_q[0] : '0;
        e_pop   = e_write && out_full_n && out_write_ce;
        e_read  = !reset && in_empty_n && in_read_ce &&
                  !((acc.size() == R - 1 || eot_m) && e_write && !e_pop);
        if (reset) begin
            acc.delete();
            exp_q.delete();
            keep_q.delete();
        end else begin
            if (e_pop) begin
                void'(exp_q.pop_front());
                void'(keep_q.pop_front());
            end
            if (e_read) begin
                acc.push_back(in_dout);
                if (acc.size() == R || eot_m) begin
                    w = '0;
                    k = '0;
                    for (int i = 0; i < acc.size(); i++) begin
                        w[i*IW +: IW] = acc[i];
                        k[i] = 1'b1;
                    end
                    exp_q.push_back(w);
                    keep_q.push_back(k);
                    acc.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_empty_n = 1'b1;
        in_read_ce = 1'b1;
        in_dout = 8'h5A;
        out_full_n = 1'b1;
        out_write_ce = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (o_read !== 1'b0) begin
                bad++;
                $display("FAIL rst_read c=%0d got=%b want=0", c, o_read);
            end
            total++;
            if (o_write !== 1'b0) begin
                bad++;
                $display("FAIL rst_write c=%0d got=%b want=0", c, o_write);
            end
            total++;
            if (o_din !== '0) begin
                bad++;
                $display("FAIL rst_din c=%0d got=%h want=0", c, o_din);
            end
        end
        reset = 1'b0;
        in_empty_n = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [IW-1:0] v[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            in_empty_n = 1'b1;
            in_dout = v[i];
            step();
            total++;
            if (o_read !== 1'b1) begin
                bad++;
                $display("FAIL basic_read i=%0d got=%b want=1", i, o_read);
            end
        end
        in_empty_n = 1'b0;
        step();
        total++;
        if (o_write !== 1'b1 || o_din !== 32'h44332211) begin
            bad++;
            $display("FAIL basic_emit got=%b/%h want=1/44332211",
                     o_write, o_din);
        end
        step();
        total++;
        if (o_write !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain got=%b want=0", o_write);
        end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] got[$];
        logic [OW-1:0] want[4] = '{32'h04030201, 32'h08070605,
                                   32'h0C0B0A09, 32'h100F0E0D};
        for (int i = 1; i <= 17; i++) begin
            in_empty_n = (i <= 16);
            in_dout = IW'(i);
            step();
            if (i <= 16) begin
                total++;
                if (o_read !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_read i=%0d got=%b want=1", i, o_read);
                end
            end
            if (o_write === 1'b1) got.push_back(o_din);
        end
        total++;
        if (got.size() != 4) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=4", got.size());
        end
        for (int j = 0; j < 4 && j < got.size(); j++) begin
            total++;
            if (got[j] !== want[j]) begin
                bad++;
                $display("FAIL b2b_word j=%0d got=%h want=%h",
                         j, got[j], want[j]);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            in_empty_n = 1'b1;
            in_dout = 8'h21 + IW'(i);
            step();
        end
        out_full_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_dout = 8'h31 + IW'(i);
            step();
            total++;
            if (o_read !== 1'b1 || o_din !== 32'h24232221) begin
                bad++;
                $display("FAIL bp_fill i=%0d got=%b/%h want=1/24232221",
                         i, o_read, o_din);
            end
        end
        in_dout = 8'h34;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (o_read !== 1'b0 || o_write !== 1'b1 ||
                o_din !== 32'h24232221) begin
                bad++;
                $display("FAIL bp_stall i=%0d got=%b/%b/%h want=0/1/24232221",
                         i, o_read, o_write, o_din);
            end
        end
        out_full_n = 1'b1;
        step();
        total++;
        if (o_read !== 1'b1 || o_din !== 32'h24232221) begin
            bad++;
            $display("FAIL bp_release got=%b/%h want=1/24232221",
                     o_read, o_din);
        end
        in_empty_n = 1'b0;
        step();
        total++;
        if (o_write !== 1'b1 || o_din !== 32'h34333231) begin
            bad++;
            $display("FAIL bp_next got=%b/%h want=1/34333231", o_write, o_din);
        end
        step();
    endtask

    task automatic test_reset_mid();
        in_empty_n = 1'b1;
        in_dout = 8'hAA;
        step();
        in_dout = 8'hBB;
        step();
        reset = 1'b1;
        in_dout = 8'hCC;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (o_read !== 1'b0 || o_write !== 1'b0) begin
                bad++;
                $display("FAIL rmid_hold c=%0d got=%b/%b want=0/0",
                         c, o_read, o_write);
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_dout = IW'(i);
            step();
        end
        in_empty_n = 1'b0;
        step();
        total++;
        if (o_write !== 1'b1 || o_din !== 32'h04030201) begin
            bad++;
            $display("FAIL rmid_word got=%b/%h want=1/04030201", o_write, o_din);
        end
        step();
    endtask

    task automatic test_random();
        int fed  = 0;
        int pops = 0;
        int cyc  = 0;
        in_dout = IW'($urandom);
        while (fed < 1000 && cyc < 20000) begin
            in_empty_n   = ($urandom_range(0, 3) != 0);
            in_read_ce   = ($urandom_range(0, 3) != 0);
            out_full_n   = ($urandom_range(0, 2) != 0);
            out_write_ce = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
            total++;
            if (o_read !== e_read || o_write !== e_write) begin
                bad++;
                $display("FAIL rnd_ctl cyc=%0d got=%b/%b want=%b/%b",
                         cyc, o_read, o_write, e_read, e_write);
            end
            if (e_write) begin
                total++;
                if (o_din !== e_din) begin
                    bad++;
                    $display("FAIL rnd_din cyc=%0d got=%h want=%h",
                             cyc, o_din, e_din);
                end
            end
            if (o_write && out_full_n && out_write_ce) pops++;
            if (e_read) begin
                fed++;
                in_dout = IW'($urandom);
            end
        end
        total++;
        if (fed < 1000) begin
            bad++;
            $display("FAIL rnd_timeout got=%0d want=1000", fed);
        end
        in_empty_n   = 1'b0;
        in_read_ce   = 1'b1;
        out_full_n   = 1'b1;
        out_write_ce = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (e_write) begin
                total++;
                if (o_din !== e_din) begin
                    bad++;
                    $display("FAIL rnd_drain got=%h want=%h", o_din, e_din);
                end
            end
            if (o_write && out_full_n && out_write_ce) pops++;
        end
        total++;
        if (pops != 250) begin
            bad++;
            $display("FAIL rnd_pops got=%0d want=250", pops);
        end
    endtask

`ifdef STREAM_PACKER_EOT_EN
    task automatic test_eot();
        in_empty_n = 1'b1;
        in_dout = 8'h11;
        in_eot = 1'b0;
        step();
        in_dout = 8'h22;
        in_eot = 1'b1;
        step();
        in_empty_n = 1'b0;
        in_eot = 1'b0;
        step();
        total++;
        if (o_write !== 1'b1 || o_din !== 32'h00002211 ||
            o_keep !== 4'b0011) begin
            bad++;
            $display("FAIL eot_short got=%b/%h/%b want=1/00002211/0011",
                     o_write, o_din, o_keep);
        end
        for (int i = 1; i <= 4; i++) begin
            in_empty_n = 1'b1;
            in_dout = 8'h50 + IW'(i);
            step();
        end
        in_empty_n = 1'b0;
        step();
        total++;
        if (o_din !== 32'h54535251 || o_keep !== 4'b1111) begin
            bad++;
            $display("FAIL eot_full got=%h/%b want=54535251/1111",
                     o_din, o_keep);
        end
        step();
    endtask
`endif

    initial begin
`ifdef STREAM_PACKER_EOT_EN
        in_eot = 1'b0;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef STREAM_PACKER_EOT_EN
        test_eot();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
